// File: rtl/sarray_feed_ctrl_if.sv
// Handshake and bank-feed signal bundle for sarray_feed_ctrl.
// slave is the sequencer's view; master is the issue logic / operand buffer / bank side.
interface sarray_feed_ctrl_if #(
   parameter int LOAD_WIDTH = 256,
   parameter int CNT_WIDTH  = 8,
   parameter int PREC_WIDTH = 2
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [CNT_WIDTH-1:0]  cmd_k_i;
   logic                  cmd_type_i;
   logic [PREC_WIDTH-1:0] cmd_precision_i;
   logic                  cmd_acc_i;

   logic                  a_valid_i;
   logic                  a_ready_o;
   logic [LOAD_WIDTH-1:0] a_data_i;
   logic                  b_valid_i;
   logic                  b_ready_o;
   logic [LOAD_WIDTH-1:0] b_data_i;

   logic                  left_valid_o;
   logic [CNT_WIDTH-1:0]  left_cnt_o;
   logic                  left_type_o;
   logic [PREC_WIDTH-1:0] left_precision_o;
   logic                  left_acc_o;
   logic [LOAD_WIDTH-1:0] left_data_o;
   logic                  top_valid_o;
   logic [CNT_WIDTH-1:0]  top_cnt_o;
   logic [LOAD_WIDTH-1:0] top_data_o;

   logic                  busy_o;
   logic                  done_o;

   modport slave (
      input  cmd_valid_i, cmd_k_i, cmd_type_i, cmd_precision_i, cmd_acc_i,
      input  a_valid_i, a_data_i, b_valid_i, b_data_i,
      output cmd_ready_o, a_ready_o, b_ready_o,
      output left_valid_o, left_cnt_o, left_type_o, left_precision_o, left_acc_o, left_data_o,
      output top_valid_o, top_cnt_o, top_data_o,
      output busy_o, done_o
   );

   modport master (
      output cmd_valid_i, cmd_k_i, cmd_type_i, cmd_precision_i, cmd_acc_i,
      output a_valid_i, a_data_i, b_valid_i, b_data_i,
      input  cmd_ready_o, a_ready_o, b_ready_o,
      input  left_valid_o, left_cnt_o, left_type_o, left_precision_o, left_acc_o, left_data_o,
      input  top_valid_o, top_cnt_o, top_data_o,
      input  busy_o, done_o
   );
endinterface

// File: rtl/sarray_feed_ctrl.sv
// TMMA feed sequencer: pulls K joint A/B row beats into the left/top skew banks,
// waits a fixed drain period, then pulses done.
module sarray_feed_ctrl #(
   parameter int SARRAY_H     = 8,
   parameter int LOAD_WIDTH   = 256,
   parameter int CNT_WIDTH    = 8,
   parameter int PREC_WIDTH   = 2,
   parameter int DRAIN_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   sarray_feed_ctrl_if.slave  bus
);
   localparam int LANE_W  = LOAD_WIDTH / SARRAY_H;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

   state_e                           state_q, state_d;
   logic [CNT_WIDTH-1:0]             k_q, k_d;
   logic [CNT_WIDTH-1:0]             idx_q, idx_d;
   logic [DRAIN_W-1:0]               drain_q, drain_d;
   logic                             type_q, type_d;
   logic [PREC_WIDTH-1:0]            prec_q, prec_d;
   logic                             acc_q, acc_d;
   logic                             valid_q, valid_d;
   logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
   logic [SARRAY_H-1:0][LANE_W-1:0]  left_q, left_d;
   logic [SARRAY_H-1:0][LANE_W-1:0]  top_q, top_d;

   logic fire;
   logic last_beat;

   // Operand streams are consumed only as a pair.
   assign fire      = (state_q == S_FEED) && bus.a_valid_i && bus.b_valid_i;
   assign last_beat = (idx_q == k_q - CNT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         idx_q   <= '0;
         drain_q <= '0;
         type_q  <= 1'b0;
         prec_q  <= '0;
         acc_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         left_q  <= '0;
         top_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
         type_q  <= type_d;
         prec_q  <= prec_d;
         acc_q   <= acc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         top_q   <= top_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      type_d  = type_q;
      prec_d  = prec_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid_i) begin
               type_d  = bus.cmd_type_i;
               prec_d  = bus.cmd_precision_i;
               acc_d   = bus.cmd_acc_i;
               k_d     = bus.cmd_k_i;
               idx_d   = '0;
               // An empty command skips both feed and drain.
               state_d = (bus.cmd_k_i != '0) ? S_FEED : S_DONE;
            end
         end
         S_FEED: begin
            if (fire) begin
               idx_d = idx_q + CNT_WIDTH'(1);
               if (last_beat) begin
                  state_d = S_DRAIN;
                  drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Beat register: data holds between fires, valid does not.
   always_comb begin
      valid_d = fire;
      cnt_d   = fire ? idx_q : cnt_q;
      left_d  = fire ? bus.a_data_i : left_q;
      top_d   = fire ? bus.b_data_i : top_q;
   end

   always_comb begin
      bus.cmd_ready_o      = (state_q == S_IDLE);
      bus.a_ready_o        = (state_q == S_FEED) && bus.b_valid_i;
      bus.b_ready_o        = (state_q == S_FEED) && bus.a_valid_i;
      bus.busy_o           = (state_q != S_IDLE);
      bus.done_o           = (state_q == S_DONE);
      bus.left_valid_o     = valid_q;
      bus.left_cnt_o       = cnt_q;
      bus.left_type_o      = type_q;
      bus.left_precision_o = prec_q;
      bus.left_acc_o       = acc_q;
      bus.left_data_o      = left_q;
      bus.top_valid_o      = valid_q;
      bus.top_cnt_o        = cnt_q;
      bus.top_data_o       = top_q;
   end
endmodule
